handshake_fifo_buffer: RTL and testbench

- Elastic FIFO buffer stage placed directly downstream of handshake constant/producer units. Stores up to NUM_SLOTS tokens.
- Cuts the combinational valid/ready path. Without it, the constant's ctrl_ready equals outs_ready directly.
- Lets the producer run ahead of a stalled consumer.
- Standard valid/ready channel on both sides: token transfers when valid && ready at a rising clk edge.

---
 rtl/handshake_pkg.sv | 15 +
 rtl/handshake_fifo_ptr.sv | 35 +++
 rtl/handshake_fifo_buffer.sv | 97 +++++++++
 tb/tb_handshake_fifo_buffer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/handshake_pkg.sv
// Shared sizing helpers for the handshake FIFO buffer and its pointer registers.
package handshake_pkg;

    localparam int MAX_SLOTS = 64;

    // Pointer width; a depth of 1 would otherwise collapse to zero bits.
    function automatic int ptr_w(input int num_slots);
        return (num_slots < 2) ? 1 : $clog2(num_slots);
    endfunction

    function automatic int cnt_w(input int num_slots);
        return $clog2(num_slots + 1);
    endfunction

endpackage

// File: rtl/handshake_fifo_ptr.sv
// Wrap-around slot pointer with enable; wraps explicitly at NUM_SLOTS-1 so any depth works.
module handshake_fifo_ptr
    import handshake_pkg::*;
#(
    parameter int NUM_SLOTS = 2,
    localparam int PTR_W = ptr_w(NUM_SLOTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_SLOTS - 1);

    logic [PTR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/handshake_fifo_buffer.sv
// Elastic valid/ready FIFO stage that breaks the combinational ready path.
// Optional same-cycle pass-through when empty: define HANDSHAKE_FIFO_BYPASS_EN.
module handshake_fifo_buffer
    import handshake_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLOTS  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int PTR_W = ptr_w(NUM_SLOTS);
    localparam int CNT_W = cnt_w(NUM_SLOTS);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SLOTS);

    if (NUM_SLOTS < 2 || NUM_SLOTS > MAX_SLOTS) begin : g_bad_depth
        $error("handshake_fifo_buffer: NUM_SLOTS out of range 2..64");
    end

    logic [DATA_WIDTH-1:0] mem_q [NUM_SLOTS];
    logic [DATA_WIDTH-1:0] mem_d [NUM_SLOTS];
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      head_ptr, tail_ptr;
    logic                  empty, full, push, pop, wr_en, rd_en;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == FULL_CNT);
        // Gated with reset so the producer sees no ready while the buffer is held in reset.
        ins_ready = rst & ~full;
        push      = ins_valid & ins_ready;
`ifdef HANDSHAKE_FIFO_BYPASS_EN
        outs_valid = ~empty | (rst & ins_valid);
        outs       = (empty & rst & ins_valid) ? ins : mem_q[head_ptr];
        pop        = outs_valid & outs_ready;
        // A token that passes straight through is neither stored nor popped from storage.
        wr_en      = push & ~(empty & outs_ready);
        rd_en      = pop & ~empty;
`else
        outs_valid = ~empty;
        outs       = mem_q[head_ptr];
        pop        = outs_valid & outs_ready;
        wr_en      = push;
        rd_en      = pop;
`endif
    end

    always_comb begin
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[tail_ptr] = ins;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    handshake_fifo_ptr #(.NUM_SLOTS(NUM_SLOTS)) u_head_ptr (
        .clk (clk),
        .rst (rst),
        .en  (rd_en),
        .ptr (head_ptr)
    );

    handshake_fifo_ptr #(.NUM_SLOTS(NUM_SLOTS)) u_tail_ptr (
        .clk (clk),
        .rst (rst),
        .en  (wr_en),
        .ptr (tail_ptr)
    );

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// Bench for handshake_fifo_buffer: a depth-2 and a depth-3 instance checked against queue models.
`timescale 1ns/1ps
module tb_handshake_fifo_buffer;

`ifdef HANDSHAKE_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [31:0] ins0 = '0, ins1 = '0;
    logic        iv0 = 1'b0, iv1 = 1'b0;
    logic        or0 = 1'b0, or1 = 1'b0;
    logic [31:0] outs0, outs1;
    logic        ov0, ov1, ir0, ir1;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] got[$];

    always #5 clk = ~clk;

    handshake_fifo_buffer #(.DATA_WIDTH(32), .NUM_SLOTS(2)) dut2 (
        .clk(clk), .rst(rst_n), .ins(ins0), .ins_valid(iv0), .ins_ready(ir0),
        .outs(outs0), .outs_valid(ov0), .outs_ready(or0)
    );

    handshake_fifo_buffer #(.DATA_WIDTH(32), .NUM_SLOTS(3)) dut3 (
        .clk(clk), .rst(rst_n), .ins(ins1), .ins_valid(iv1), .ins_ready(ir1),
        .outs(outs1), .outs_valid(ov1), .outs_ready(or1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a plain queue per instance; transfers decided from pre-edge occupancy.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end else begin
            if (!(BYP && q0.size() == 0 && iv0 && or0)) begin
                automatic bit pop0  = (q0.size() > 0) && or0;
                automatic bit push0 = iv0 && (q0.size() < 2);
                if (pop0)  void'(q0.pop_front());
                if (push0) q0.push_back(ins0);
            end
            if (!(BYP && q1.size() == 0 && iv1 && or1)) begin
                automatic bit pop1  = (q1.size() > 0) && or1;
                automatic bit push1 = iv1 && (q1.size() < 3);
                if (pop1)  void'(q1.pop_front());
                if (push1) q1.push_back(ins1);
            end
        end
    end

    always @(negedge clk) begin
        automatic bit          ev0 = (q0.size() > 0) || (BYP && rst_n && iv0);
        automatic bit          ev1 = (q1.size() > 0) || (BYP && rst_n && iv1);
        automatic logic [31:0] ed0 = (q0.size() > 0) ? q0[0] : ins0;
        automatic logic [31:0] ed1 = (q1.size() > 0) ? q1[0] : ins1;
        chk("m2 ins_ready",  {31'd0, ir0}, {31'd0, rst_n && (q0.size() < 2)});
        chk("m2 outs_valid", {31'd0, ov0}, {31'd0, ev0});
        if (!rst_n)   chk("m2 outs in reset", outs0, 32'd0);
        else if (ev0) chk("m2 outs", outs0, ed0);
        chk("m3 ins_ready",  {31'd0, ir1}, {31'd0, rst_n && (q1.size() < 3)});
        chk("m3 outs_valid", {31'd0, ov1}, {31'd0, ev1});
        if (!rst_n)   chk("m3 outs in reset", outs1, 32'd0);
        else if (ev1) chk("m3 outs", outs1, ed1);
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a valid producer.
        iv0 = 1'b1; ins0 = 32'h55; iv1 = 1'b1; ins1 = 32'h66;
        repeat (3) cyc();
        chk("rst ins_ready",  {31'd0, ir0}, 32'd0);
        chk("rst outs_valid", {31'd0, ov0}, 32'd0);
        chk("rst outs",       outs0, 32'd0);
        chk("rst ins_ready3", {31'd0, ir1}, 32'd0);
        iv0 = 1'b0; iv1 = 1'b0;
        rst_n = 1'b1;
        cyc();
        chk("post-rst ins_ready",  {31'd0, ir0}, 32'd1);
        chk("post-rst outs_valid", {31'd0, ov0}, 32'd0);

        // Fill and drain, depth 2.
        or0 = 1'b0; iv0 = 1'b1; ins0 = 32'h17;
        cyc();
        chk("fill1 outs_valid", {31'd0, ov0}, 32'd1);
        chk("fill1 outs",       outs0, 32'h17);
        chk("fill1 ins_ready",  {31'd0, ir0}, 32'd1);
        ins0 = 32'h2A;
        cyc();
        chk("fill2 ins_ready", {31'd0, ir0}, 32'd0);
        chk("fill2 outs",      outs0, 32'h17);
        iv0 = 1'b0; or0 = 1'b1;
        cyc();
        chk("drain1 outs",      outs0, 32'h2A);
        chk("drain1 ins_ready", {31'd0, ir0}, 32'd1);
        cyc();
        chk("drain2 outs_valid", {31'd0, ov0}, 32'd0);

        // Full with simultaneous pop: push refused that cycle, accepted the next.
        or0 = 1'b0; iv0 = 1'b1; ins0 = 32'h01;
        cyc();
        ins0 = 32'h02;
        cyc();
        chk("full ins_ready", {31'd0, ir0}, 32'd0);
        ins0 = 32'h03; or0 = 1'b1;
        cyc();
        chk("fullpop ins_ready", {31'd0, ir0}, 32'd1);
        chk("fullpop outs",      outs0, 32'h02);
        or0 = 1'b0;
        cyc();
        chk("refill ins_ready", {31'd0, ir0}, 32'd0);
        chk("refill outs",      outs0, 32'h02);
        iv0 = 1'b0; or0 = 1'b1;
        cyc();
        chk("fp drain outs", outs0, 32'h03);
        cyc();
        chk("fp drain empty", {31'd0, ov0}, 32'd0);
        or0 = 1'b0;

        // Depth 3 stream 0..9 with the consumer toggling.
        begin
            automatic int idx = 0;
            for (int c = 0; c < 60 && got.size() < 10; c++) begin
                iv1 = (idx < 10);
                ins1 = idx;
                or1 = (c % 2 == 0);
                #1;
                if (ov1 && or1) got.push_back(outs1);
                if (iv1 && ir1) idx++;
                cyc();
            end
            iv1 = 1'b0; or1 = 1'b0;
            chk("wrap count", got.size(), 32'd10);
            for (int k = 0; k < 10; k++) begin
                chk("wrap seq", (k < got.size()) ? got[k] : 32'hDEAD, k);
            end
        end

        // Mid-stream reset pulse inside the low clock phase.
        or0 = 1'b0; iv0 = 1'b1; ins0 = 32'hAA;
        cyc();
        ins0 = 32'hBB;
        cyc();
        iv0 = 1'b0;
        chk("pre-rst outs", outs0, 32'hAA);
        #1 rst_n = 1'b0;
        #1;
        chk("async rst outs_valid", {31'd0, ov0}, 32'd0);
        chk("async rst ins_ready",  {31'd0, ir0}, 32'd0);
        chk("async rst outs",       outs0, 32'd0);
        #1 rst_n = 1'b1;
        cyc();
        chk("after rst empty", {31'd0, ov0}, 32'd0);
        ins0 = 32'hCC; iv0 = 1'b1; or0 = 1'b1;
        cyc();
        chk("after rst next outs", outs0, 32'hCC);
        iv0 = 1'b0;
        cyc();
        chk("after rst drained", {31'd0, ov0}, 32'd0);

        // Latency from empty: same cycle with bypass, one cycle later without.
        ins0 = 32'h17; iv0 = 1'b1; or0 = 1'b1;
        #1;
        chk("byp same-cycle valid", {31'd0, ov0}, BYP ? 32'd1 : 32'd0);
        if (BYP) chk("byp same-cycle outs", outs0, 32'h17);
        cyc();
        iv0 = 1'b0;
        #1;
        chk("byp next valid", {31'd0, ov0}, BYP ? 32'd0 : 32'd1);
        if (!BYP) chk("nobyp next outs", outs0, 32'h17);
        cyc();
        chk("byp end empty", {31'd0, ov0}, 32'd0);
        or0 = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
